// File: rtl/motor_pwm_generator_pkg.sv
// Shared constants and state encodings for the motor PWM generator and the mixer.
package motor_pwm_generator_pkg;

    localparam int MOTOR_RATE_BIT_WIDTH = 8;
    localparam int PWM_PERIOD_TICKS     = 95000;
    localparam int PWM_MIN_PULSE_TICKS  = 38000;
    localparam int PWM_STEP_TICKS       = 148;
    localparam int PWM_ARM_FRAMES       = 400;
    localparam int PWM_CNT_WIDTH        = 17;

    typedef enum logic {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/motor_pwm_generator_pwm_channel.sv
// One ESC output: shadow rate -> saturated target -> frame-aligned width -> registered pulse.
module pwm_channel
    import motor_pwm_generator_pkg::*;
#(
    parameter int PERIOD_TICKS    = PWM_PERIOD_TICKS,
    parameter int MIN_PULSE_TICKS = PWM_MIN_PULSE_TICKS,
    parameter int STEP_TICKS      = PWM_STEP_TICKS,
    parameter int CNT_WIDTH       = PWM_CNT_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [CNT_WIDTH-1:0]            cnt_i,
    input  logic                            sample_i,
    input  logic                            compute_i,
    input  logic                            load_i,
    input  logic                            eff_en_i,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] rate_i,
    output logic                            pwm_o
);

    localparam int TGT_W = CNT_WIDTH + 1;

    logic [MOTOR_RATE_BIT_WIDTH-1:0] shadow_q, shadow_d;
    logic [TGT_W-1:0]                target_q, target_d;
    logic [TGT_W-1:0]                width_q, width_d;
    logic                            pwm_q, pwm_d;

    // Pulse can never exceed the frame, so the ESC always sees at least one low cycle.
    function automatic logic [TGT_W-1:0] sat_target(input logic [MOTOR_RATE_BIT_WIDTH-1:0] rate);
        logic [31:0]      sum;
        logic [TGT_W-1:0] res;
        sum = 32'(MIN_PULSE_TICKS) + 32'(rate) * 32'(STEP_TICKS);
        if (sum > 32'(PERIOD_TICKS - 1)) begin
            res = TGT_W'(PERIOD_TICKS - 1);
        end else begin
            res = TGT_W'(sum);
        end
        return res;
    endfunction

    always_comb begin
        shadow_d = shadow_q;
        target_d = target_q;
        width_d  = width_q;
        if (sample_i) begin
            shadow_d = rate_i;
        end
        if (compute_i) begin
            target_d = eff_en_i ? sat_target(shadow_q) : TGT_W'(MIN_PULSE_TICKS);
        end
        if (load_i) begin
            width_d = target_q;
        end
        pwm_d = ({1'b0, cnt_i} < width_q);
    end

    always_ff @(posedge clk_i) begin
        shadow_q <= shadow_d;
        target_q <= target_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            width_q <= TGT_W'(MIN_PULSE_TICKS);
            pwm_q   <= 1'b0;
        end else begin
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_pwm_generator.sv
// Four-channel ESC PWM generator with post-reset arming sequence and per-frame rate sampling.
module motor_pwm_generator
    import motor_pwm_generator_pkg::*;
#(
    parameter int PERIOD_TICKS    = PWM_PERIOD_TICKS,
    parameter int MIN_PULSE_TICKS = PWM_MIN_PULSE_TICKS,
    parameter int STEP_TICKS      = PWM_STEP_TICKS,
    parameter int ARM_FRAMES      = PWM_ARM_FRAMES,
    parameter int CNT_WIDTH       = PWM_CNT_WIDTH
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate,
    output logic                            motor_1_pwm,
    output logic                            motor_2_pwm,
    output logic                            motor_3_pwm,
    output logic                            motor_4_pwm,
    output logic                            frame_start,
    output logic                            armed
);

    localparam int ARM_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(PERIOD_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_SAMPLE  = CNT_WIDTH'(PERIOD_TICKS - 3);
    localparam logic [CNT_WIDTH-1:0] CNT_COMPUTE = CNT_WIDTH'(PERIOD_TICKS - 2);
    localparam logic [ARM_W-1:0]     ARM_LAST    = ARM_W'(ARM_FRAMES - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ARM_W-1:0]     arm_cnt_q, arm_cnt_d;
    pwm_state_e           state_q, state_d;
    logic                 armed_q, armed_d;
    logic                 frame_start_q, frame_start_d;
    logic                 eff_en_q, eff_en_d;
    logic                 wrap, sample, compute;

    logic [3:0][MOTOR_RATE_BIT_WIDTH-1:0] rates;
    logic [3:0]                           pwm;

    assign wrap    = (cnt_q == CNT_LAST);
    assign sample  = (cnt_q == CNT_SAMPLE);
    assign compute = (cnt_q == CNT_COMPUTE);

    always_comb begin
        cnt_d         = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
        frame_start_d = (cnt_q == '0);
        eff_en_d      = sample ? (enable && (state_q == ST_RUN)) : eff_en_q;
    end

    // Arming: count frame wraps, then latch into RUN until the next reset.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        case (state_q)
            ST_ARM: begin
                if (wrap) begin
                    if (arm_cnt_q == ARM_LAST) begin
                        state_d = ST_RUN;
                        armed_d = 1'b1;
                    end else begin
                        arm_cnt_d = arm_cnt_q + ARM_W'(1);
                    end
                end
            end
            ST_RUN: begin
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q         <= '0;
            arm_cnt_q     <= '0;
            state_q       <= ST_ARM;
            armed_q       <= 1'b0;
            frame_start_q <= 1'b0;
            eff_en_q      <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            arm_cnt_q     <= arm_cnt_d;
            state_q       <= state_d;
            armed_q       <= armed_d;
            frame_start_q <= frame_start_d;
            eff_en_q      <= eff_en_d;
        end
    end

    assert property (@(posedge sys_clk) ARM_FRAMES != 0)
        else $error("motor_pwm_generator: ARM_FRAMES must be nonzero");

    assign rates = {motor_4_rate, motor_3_rate, motor_2_rate, motor_1_rate};

    for (genvar n = 0; n < 4; n++) begin : g_ch
        pwm_channel #(
            .PERIOD_TICKS   (PERIOD_TICKS),
            .MIN_PULSE_TICKS(MIN_PULSE_TICKS),
            .STEP_TICKS     (STEP_TICKS),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_ch (
            .clk_i    (sys_clk),
            .rst_i    (reset),
            .cnt_i    (cnt_q),
            .sample_i (sample),
            .compute_i(compute),
            .load_i   (wrap),
            .eff_en_i (eff_en_q),
            .rate_i   (rates[n]),
            .pwm_o    (pwm[n])
        );
    end

    assign motor_1_pwm = pwm[0];
    assign motor_2_pwm = pwm[1];
    assign motor_3_pwm = pwm[2];
    assign motor_4_pwm = pwm[3];
    assign frame_start = frame_start_q;
    assign armed       = armed_q;

endmodule

// File: doc/motor_pwm_generator.md
Name: motor_pwm_generator

Overview:
- Downstream of the motor mixer. Consumes the four 8-bit motor rates and drives four ESC servo-style PWM outputs (nominal 1000–2000 us pulse, 400 Hz frame).
- Sequences a mandatory ESC arming period of minimum-throttle pulses after reset.
- Samples rates once per frame into shadow registers, so pulses never glitch mid-frame.

Parameters:
- PERIOD_TICKS, 95000: sys_clk cycles per PWM frame (2.5 ms at 38 MHz).
- MIN_PULSE_TICKS, 38000: pulse width for rate 0 (1000 us).
- STEP_TICKS, 148: added ticks per rate LSB.
- ARM_FRAMES, 400: frames of forced minimum pulse after reset.
- CNT_WIDTH, 17: frame counter width; must hold PERIOD_TICKS-1.

Ports:
- sys_clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = fly using motor rates; 0 = force minimum pulse
- motor_1_rate  input  8  unsigned rate from mixer
- motor_2_rate  input  8  unsigned rate from mixer
- motor_3_rate  input  8  unsigned rate from mixer
- motor_4_rate  input  8  unsigned rate from mixer
- motor_1_pwm  output  1  ESC pulse, registered
- motor_2_pwm  output  1  ESC pulse, registered
- motor_3_pwm  output  1  ESC pulse, registered
- motor_4_pwm  output  1  ESC pulse, registered
- frame_start  output  1  one-cycle strobe, coincident with pulse rising edges
- armed  output  1  high once arming is complete

Behaviour:
- Reset (sampled on sys_clk rising edge while reset=1):
  - frame cnt=0; arm_cnt=0; state=ST_ARM.
  - All width_n=MIN_PULSE_TICKS.
  - All pwm outputs=0, frame_start=0, armed=0.
  - Takes effect the cycle after assertion. Reset mid-pulse truncates the pulse; this is required behaviour.
- Frame counter: cnt counts 0..PERIOD_TICKS-1 and wraps to 0. It is free-running outside reset.
- Sampling pipeline:
  - At cnt==PERIOD_TICKS-3, latch the four rates into shadow regs. Also latch eff_en = enable AND (state==ST_RUN).
  - At cnt==PERIOD_TICKS-2, compute target_n = MIN_PULSE_TICKS + shadow_n*STEP_TICKS in a CNT_WIDTH+1-bit unsigned register. If target_n > PERIOD_TICKS-1, clamp to PERIOD_TICKS-1. If eff_en=0, force target_n to MIN_PULSE_TICKS.
  - At cnt==PERIOD_TICKS-1, copy target_n into width_n.
  - width_n changes only then. Rate or enable changes at any other cycle affect only the next frame.
- Output timing:
  - The cycle after cnt holds value c, motor_n_pwm = (c < width_n).
  - Each pulse is therefore high for exactly width_n consecutive cycles per frame.
  - The first frame after reset is a full MIN_PULSE_TICKS pulse.
  - frame_start=1 in the cycle after cnt==0.
- State machine:
  - ST_ARM: arm_cnt increments on each cnt wrap (PERIOD_TICKS-1 → 0). When arm_cnt reaches ARM_FRAMES-1 at a wrap, go to ST_RUN and set armed=1 on that same edge.
  - ST_RUN: terminal until reset. arm_cnt holds.
  - With the pipeline above, the first rate-driven frame is frame index ARM_FRAMES+1 (0-based), since the sample at PERIOD_TICKS-3 of frame ARM_FRAMES-1 still sees ST_ARM.
- Enable:
  - Dropping enable mid-frame does not shorten the current pulse; the next frame uses the minimum width.
  - enable is ignored in ST_ARM.
  - enable does not affect arming.
- Arithmetic: unsigned only. Mixer rates are already clamped 0..255, so no sign handling is needed.
- ARM_FRAMES=0 is illegal. Add a simulation-time assertion for it.

Decomposition:
- Add to common_defines.v:
  - MOTOR_RATE_BIT_WIDTH (8), already shared with the mixer.
  - PWM_PERIOD_TICKS, PWM_MIN_PULSE_TICKS, PWM_STEP_TICKS defaults.
  - The state encodings ST_ARM and ST_RUN.
- One natural sub-module: pwm_channel, instantiated 4×.
  - Holds shadow rate, target and width registers for one motor.
  - Produces its registered pwm output from the shared cnt and control strobes.
- The top level owns cnt, arm_cnt, the FSM, frame_start and armed.

Test Plan:
Bench parameters: PERIOD_TICKS=1000, MIN_PULSE_TICKS=100, STEP_TICKS=2, ARM_FRAMES=3, CNT_WIDTH=10.
1. Reset release, enable=1, all rates 255 -> frames 0–3 each pulse exactly 100 cycles high. armed rises at the end of frame 2. Frame 4 pulses are 610 cycles. Pulses repeat every 1000 cycles.
2. Armed; rates 0/64/128/255 on motors 1–4 -> widths 100/228/356/610 cycles. All rising edges are coincident with frame_start.
3. Armed, rate 255; change motor_1_rate to 10 at cnt=500 -> current pulse stays 610 cycles, next pulse is 120 cycles. Change at cnt=998 (after sample) -> takes effect one frame later.
4. Armed, rates 200, enable=0 mid-pulse at cnt=300 -> current pulse completes at 500 cycles, next frame is 100 cycles. enable=1 again -> 500 cycles resumes next frame.
5. Assert reset at cnt=250 during a 500-cycle pulse -> all pwm=0, armed=0, frame_start=0 the next cycle. After release the full arming sequence repeats (3 min-width frames).
6. STEP_TICKS=5, rate 255 (100+1275 > 999) -> width clamps to 999 cycles high, 1 cycle low per frame.
